// File: rtl/rv_mem_arbiter.sv
// ============================================================================
// rv_mem_arbiter : shares one memory bus between uRV fetch and load/store ports
// Optional: RV_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv_mem_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] im_addr_i,
  input  logic        im_rd_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DLOAD  = 2'd2,
    ST_DSTORE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic        pend_store_q, pend_store_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [3:0]  pend_sel_q, pend_sel_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  mem_sel_q, mem_sel_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] im_data_q, im_data_d;
  logic        im_valid_q, im_valid_d;
  logic [31:0] dm_data_l_q, dm_data_l_d;
  logic        dm_load_done_q, dm_load_done_d;
  logic        dm_store_done_q, dm_store_done_d;
  logic        dm_ready_q, dm_ready_d;
  logic        accept;
  logic        grant_data;
`ifdef RV_ARB_ROUND_ROBIN_EN
  logic        last_data_q, last_data_d;
`endif

  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    pend_store_d    = pend_store_q;
    pend_addr_d     = pend_addr_q;
    pend_data_d     = pend_data_q;
    pend_sel_d      = pend_sel_q;
    mem_addr_d      = mem_addr_q;
    mem_data_d      = mem_data_q;
    mem_sel_d       = mem_sel_q;
    mem_we_d        = mem_we_q;
    mem_req_d       = mem_req_q;
    im_data_d       = im_data_q;
    im_valid_d      = 1'b0;
    dm_data_l_d     = dm_data_l_q;
    dm_load_done_d  = 1'b0;
    dm_store_done_d = 1'b0;

    // A simultaneous load+store pulse is illegal; the store is kept.
    accept = dm_ready_q && (dm_load_i || dm_store_i);
    if (accept) begin
      pend_d       = 1'b1;
      pend_store_d = dm_store_i;
      pend_addr_d  = dm_addr_i;
      pend_data_d  = dm_data_s_i;
      pend_sel_d   = dm_data_select_i;
    end

`ifdef RV_ARB_ROUND_ROBIN_EN
    last_data_d = last_data_q;
    grant_data  = pend_q && (!im_rd_i || !last_data_q);
`else
    grant_data  = pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          state_d    = pend_store_q ? ST_DSTORE : ST_DLOAD;
          mem_addr_d = pend_addr_q;
          mem_data_d = pend_data_q;
          mem_sel_d  = pend_sel_q;
          mem_we_d   = pend_store_q;
          mem_req_d  = 1'b1;
          pend_d     = 1'b0;
`ifdef RV_ARB_ROUND_ROBIN_EN
          last_data_d = 1'b1;
`endif
        end else if (im_rd_i) begin
          state_d    = ST_FETCH;
          mem_addr_d = im_addr_i;
          mem_sel_d  = 4'hF;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
`ifdef RV_ARB_ROUND_ROBIN_EN
          last_data_d = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (mem_ack_i) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          // Stale fetch (core moved on, e.g. branch) is silently dropped.
          if (im_rd_i && (im_addr_i == mem_addr_q)) begin
            im_valid_d = 1'b1;
            im_data_d  = mem_data_i;
          end
        end
      end
      ST_DLOAD: begin
        if (mem_ack_i) begin
          state_d        = ST_IDLE;
          mem_req_d      = 1'b0;
          dm_data_l_d    = mem_data_i;
          dm_load_done_d = 1'b1;
        end
      end
      ST_DSTORE: begin
        if (mem_ack_i) begin
          state_d         = ST_IDLE;
          mem_req_d       = 1'b0;
          mem_we_d        = 1'b0;
          dm_store_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    dm_ready_d = !pend_d && ((state_d == ST_IDLE) || (state_d == ST_FETCH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      pend_q          <= 1'b0;
      pend_store_q    <= 1'b0;
      pend_addr_q     <= 32'h0;
      pend_data_q     <= 32'h0;
      pend_sel_q      <= 4'h0;
      mem_addr_q      <= 32'h0;
      mem_data_q      <= 32'h0;
      mem_sel_q       <= 4'h0;
      mem_we_q        <= 1'b0;
      mem_req_q       <= 1'b0;
      im_data_q       <= 32'h0;
      im_valid_q      <= 1'b0;
      dm_data_l_q     <= 32'h0;
      dm_load_done_q  <= 1'b0;
      dm_store_done_q <= 1'b0;
      dm_ready_q      <= 1'b1;
`ifdef RV_ARB_ROUND_ROBIN_EN
      last_data_q     <= 1'b1;
`endif
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      pend_store_q    <= pend_store_d;
      pend_addr_q     <= pend_addr_d;
      pend_data_q     <= pend_data_d;
      pend_sel_q      <= pend_sel_d;
      mem_addr_q      <= mem_addr_d;
      mem_data_q      <= mem_data_d;
      mem_sel_q       <= mem_sel_d;
      mem_we_q        <= mem_we_d;
      mem_req_q       <= mem_req_d;
      im_data_q       <= im_data_d;
      im_valid_q      <= im_valid_d;
      dm_data_l_q     <= dm_data_l_d;
      dm_load_done_q  <= dm_load_done_d;
      dm_store_done_q <= dm_store_done_d;
      dm_ready_q      <= dm_ready_d;
`ifdef RV_ARB_ROUND_ROBIN_EN
      last_data_q     <= last_data_d;
`endif
    end
  end

  assign im_data_o       = im_data_q;
  assign im_valid_o      = im_valid_q;
  assign dm_ready_o      = dm_ready_q;
  assign dm_data_l_o     = dm_data_l_q;
  assign dm_load_done_o  = dm_load_done_q;
  assign dm_store_done_o = dm_store_done_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_o      = mem_data_q;
  assign mem_sel_o       = mem_sel_q;
  assign mem_we_o        = mem_we_q;
  assign mem_req_o       = mem_req_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_mem_arbiter.sv
// ============================================================================
// tb_rv_mem_arbiter : vector table + scoreboard bench for rv_mem_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv_mem_arbiter;

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] im_addr_i;
  logic        im_rd_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic        dm_ready_o;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_sel_o;
  logic        mem_we_o;
  logic        mem_req_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;

  always #5 clk = ~clk;

  rv_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .im_addr_i(im_addr_i), .im_rd_i(im_rd_i),
    .im_data_o(im_data_o), .im_valid_o(im_valid_o),
    .dm_addr_i(dm_addr_i), .dm_data_s_i(dm_data_s_i),
    .dm_data_select_i(dm_data_select_i),
    .dm_load_i(dm_load_i), .dm_store_i(dm_store_i),
    .dm_ready_o(dm_ready_o), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_sel_o(mem_sel_o), .mem_we_o(mem_we_o), .mem_req_o(mem_req_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  // Both pulses at once is a core-side protocol violation.
  always @(posedge clk) begin
    if (!rst_i) assert (!(dm_load_i && dm_store_i)) else $error("load and store pulsed together");
  end

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          delay;
    logic [3:0]  exp_sel;
    logic        exp_we;
  } vec_t;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] data;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] data);
    sb_t e;
    e.kind = kind;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Advance one cycle and compare any completion pulse against the scoreboard.
  task automatic step();
    sb_t         e;
    logic [1:0]  k;
    logic [31:0] d;
    @(negedge clk);
    if (im_valid_o || dm_load_done_o || dm_store_done_o) begin
      k = im_valid_o ? K_FETCH : (dm_load_done_o ? K_LOAD : K_STORE);
      d = im_valid_o ? im_data_o : (dm_load_done_o ? dm_data_l_o : 32'h0);
      if (sb_q.size() == 0) begin
        chk("unexpected_done", {30'h0, k}, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("done_kind", {30'h0, k}, {30'h0, e.kind});
        chk("done_data", d, e.data);
      end
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req_o && n < 20) begin
      step();
      n++;
    end
    if (!mem_req_o) chk("req_timeout", 32'h0, 32'h1);
  endtask

  task automatic pulse_data(input logic is_store, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    chk("ready_before_pulse", {31'h0, dm_ready_o}, 32'h1);
    dm_addr_i = a; dm_data_s_i = d; dm_data_select_i = s;
    dm_store_i = is_store; dm_load_i = !is_store;
    step();
    dm_store_i = 1'b0; dm_load_i = 1'b0;
    chk("ready_drop", {31'h0, dm_ready_o}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] held;
    if (v.kind == K_FETCH) begin
      im_addr_i = v.addr; im_rd_i = 1'b1;
    end else begin
      pulse_data(v.kind == K_STORE, v.addr, v.wdata, v.sel);
    end
    wait_req();
    chk($sformatf("v%0d_addr", idx), mem_addr_o, v.addr);
    chk($sformatf("v%0d_sel", idx), {28'h0, mem_sel_o}, {28'h0, v.exp_sel});
    chk($sformatf("v%0d_we", idx), {31'h0, mem_we_o}, {31'h0, v.exp_we});
    if (v.kind == K_STORE) chk($sformatf("v%0d_wdata", idx), mem_data_o, v.wdata);
    held = mem_addr_o;
    for (int i = 0; i < v.delay; i++) begin
      step();
      chk($sformatf("v%0d_hold", idx), {mem_addr_o[30:0], mem_req_o}, {held[30:0], 1'b1});
    end
    mem_ack_i = 1'b1; mem_data_i = v.rdata;
    push(v.kind, (v.kind == K_STORE) ? 32'h0 : v.rdata);
    step();
    mem_ack_i = 1'b0;
    chk($sformatf("v%0d_req_drop", idx), {31'h0, mem_req_o}, 32'h0);
    im_rd_i = 1'b0;
    step();
    chk($sformatf("v%0d_ready_back", idx), {31'h0, dm_ready_o}, 32'h1);
  endtask

  initial begin
    logic model_pend, last_data, prev_req, pulse, is_data, exp_data;
    vecs[0] = '{K_FETCH, 32'h100,  32'h0,        4'h0, 32'h0000_0013, 0, 4'hF, 1'b0};
    vecs[1] = '{K_LOAD,  32'h40,   32'h0,        4'hF, 32'h1234_5678, 5, 4'hF, 1'b0};
    vecs[2] = '{K_STORE, 32'h2000, 32'hDEADBEEF, 4'h3, 32'h0,         2, 4'h3, 1'b1};
    vecs[3] = '{K_FETCH, 32'h104,  32'h0,        4'h0, 32'hABCD_0001, 3, 4'hF, 1'b0};
    vecs[4] = '{K_LOAD,  32'h44,   32'h0,        4'h1, 32'hCAFE_F00D, 1, 4'h1, 1'b0};
    vecs[5] = '{K_STORE, 32'h48,   32'h1122_3344, 4'hC, 32'h0,        0, 4'hC, 1'b1};

    rst_i = 1'b1; im_addr_i = 32'h0; im_rd_i = 1'b0;
    dm_addr_i = 32'h0; dm_data_s_i = 32'h0; dm_data_select_i = 4'h0;
    dm_load_i = 1'b0; dm_store_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_ready", {31'h0, dm_ready_o}, 32'h1);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_sel_we", {27'h0, mem_sel_o, mem_we_o}, 32'h0);
    chk("rst_pulses", {29'h0, im_valid_o, dm_load_done_o, dm_store_done_o}, 32'h0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Store arrives during an in-flight fetch; served before the next fetch.
    im_addr_i = 32'h180; im_rd_i = 1'b1;
    wait_req();
    chk("sdf_fetch_addr", mem_addr_o, 32'h180);
    pulse_data(1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011);
    chk("sdf_fetch_stable", {mem_addr_o[30:0], mem_we_o}, {31'h180, 1'b0});
    step(); step();
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0033; push(K_FETCH, 32'h33);
    step();
    mem_ack_i = 1'b0;
    wait_req();
    chk("sdf_st_addr", mem_addr_o, 32'h2000);
    chk("sdf_st_data", mem_data_o, 32'hDEADBEEF);
    chk("sdf_st_sel_we", {27'h0, mem_sel_o, mem_we_o}, {27'h0, 4'b0011, 1'b1});
    mem_ack_i = 1'b1; push(K_STORE, 32'h0);
    step();
    mem_ack_i = 1'b0;
    chk("sdf_ready_back", {31'h0, dm_ready_o}, 32'h1);
    wait_req();
    chk("sdf_refetch", {mem_addr_o[27:0], mem_sel_o}, {28'h180, 4'hF});
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0044; push(K_FETCH, 32'h44);
    step();
    mem_ack_i = 1'b0; im_rd_i = 1'b0;
    step();

    // Branch: address changes before ack, result must be discarded.
    im_addr_i = 32'h200; im_rd_i = 1'b1;
    wait_req();
    chk("br_addr0", mem_addr_o, 32'h200);
    step();
    im_addr_i = 32'h300;
    step();
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_0BAD;
    step();
    mem_ack_i = 1'b0;
    wait_req();
    chk("br_addr1", mem_addr_o, 32'h300);
    mem_ack_i = 1'b1; mem_data_i = 32'h0000_600D; push(K_FETCH, 32'h600D);
    step();
    mem_ack_i = 1'b0; im_rd_i = 1'b0;
    step();

    // Reset while a load is on the bus; the late ack must be ignored.
    pulse_data(1'b0, 32'h80, 32'h0, 4'hF);
    wait_req();
    chk("rl_req", {31'h0, mem_req_o}, 32'h1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rl_req0", {31'h0, mem_req_o}, 32'h0);
    chk("rl_addr0", mem_addr_o, 32'h0);
    chk("rl_ldata0", dm_data_l_o, 32'h0);
    chk("rl_idata0", im_data_o, 32'h0);
    chk("rl_ready", {31'h0, dm_ready_o}, 32'h1);
    mem_ack_i = 1'b1; mem_data_i = 32'h7777_7777;
    step();
    mem_ack_i = 1'b0;
    chk("rl_no_req", {31'h0, mem_req_o}, 32'h0);
    step();

    // Contention: data pulses whenever ready while fetch is held high.
    model_pend = 1'b0; last_data = 1'b1; prev_req = mem_req_o;
    im_addr_i = 32'h400; im_rd_i = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      pulse = (cyc < 45) && dm_ready_o;
      dm_load_i = pulse; dm_addr_i = 32'h500 + cyc * 4;
      if (mem_req_o) begin
        mem_ack_i = 1'b1;
        if (mem_addr_o == 32'h400) begin
          mem_data_i = 32'h13; push(K_FETCH, 32'h13);
        end else begin
          mem_data_i = mem_addr_o ^ 32'hA5A5_0000; push(K_LOAD, mem_addr_o ^ 32'hA5A5_0000);
        end
      end else begin
        mem_ack_i = 1'b0;
      end
      step();
      if (mem_req_o && !prev_req) begin
        is_data = (mem_addr_o != 32'h400);
        if (model_pend) begin
`ifdef RV_ARB_ROUND_ROBIN_EN
          exp_data = !last_data;
`else
          exp_data = 1'b1;
`endif
          chk("cont_grant", {31'h0, is_data}, {31'h0, exp_data});
        end
        last_data = is_data;
        if (is_data) model_pend = 1'b0;
      end
      if (pulse) model_pend = 1'b1;
      prev_req = mem_req_o;
    end
    dm_load_i = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (!mem_req_o && !model_pend) break;
      if (mem_req_o) begin
        mem_ack_i = 1'b1;
        if (mem_addr_o == 32'h400) begin
          mem_data_i = 32'h13; push(K_FETCH, 32'h13);
        end else begin
          mem_data_i = mem_addr_o ^ 32'hA5A5_0000; push(K_LOAD, mem_addr_o ^ 32'hA5A5_0000);
        end
      end else begin
        mem_ack_i = 1'b0;
      end
      step();
      if (mem_req_o && !prev_req && mem_addr_o != 32'h400) model_pend = 1'b0;
      prev_req = mem_req_o;
    end
    mem_ack_i = 1'b0; im_rd_i = 1'b0;
    step(); step(); step();
    chk("sb_empty", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Shares one single-ported memory bus between the uRV instruction-fetch port and the data load/store port. It sits between `rv_cpu` and the memory or bus bridge. It latches data requests so that single-cycle pulses are not lost while a fetch is in flight, and it serializes all transfers through a req/ack handshake. Fetches whose address has changed by completion time, for example after a branch, are discarded and not delivered.

## Interface
- No parameters; address/data widths fixed at 32, byte select at 4.
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- im_addr_i  in  32  fetch address from core
- im_rd_i  in  1  fetch request level, held while core wants an instruction
- im_data_o  out  32  fetched instruction
- im_valid_o  out  1  one-cycle pulse: im_data_o valid for current im_addr_i
- dm_addr_i  in  32  data address
- dm_data_s_i  in  32  store data
- dm_data_select_i  in  4  byte enables
- dm_load_i / dm_store_i  in  1  one-cycle request pulses, accepted only when dm_ready_o=1
- dm_ready_o  out  1  data port can accept a request
- dm_data_l_o  out  32  load data
- dm_load_done_o / dm_store_done_o  out  1  one-cycle completion pulses
- mem_addr_o  out  32  shared bus address
- mem_data_o  out  32  shared bus write data
- mem_sel_o  out  4  byte enables; 4'hF for fetch
- mem_we_o  out  1  write strobe qualifier
- mem_req_o  out  1  request, held until ack
- mem_ack_i  in  1  transfer complete; mem_data_i valid in same cycle
- mem_data_i  in  32  shared bus read data

## Operation
- States: IDLE, FETCH, DLOAD, DSTORE.
- Data pending register: set on a dm_load_i or dm_store_i pulse while dm_ready_o=1. Captures addr, data, select and type. Cleared when that transfer is granted.
- dm_ready_o = !pending && state not DLOAD/DSTORE. It is registered and drops the cycle after acceptance.
- Both pulses asserted together: store wins; the load is dropped. This is a protocol violation and is flagged by a bench assertion.
- Requests arriving while dm_ready_o=0 are ignored.
- IDLE arbitration: data pending beats im_rd_i (fixed priority; see Configuration). Grant loads the mem_* outputs and sets mem_req_o.
- FETCH: im_addr_i is latched at grant. On mem_ack_i:
  - If im_rd_i is still high and im_addr_i equals the latched address, pulse im_valid_o and register im_data_o.
  - Otherwise discard the result with no pulse.
  - Return to IDLE in both cases.
- DLOAD: on ack, register dm_data_l_o, pulse dm_load_done_o, go to IDLE.
- DSTORE: mem_we_o=1. On ack, pulse dm_store_done_o, go to IDLE.
- mem_* outputs stay stable from grant until ack.
- mem_ack_i in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - mem_req_o, mem_we_o, im_valid_o, dm_load_done_o, dm_store_done_o all 0
  - dm_ready_o 1
  - mem_addr_o, mem_data_o, im_data_o, dm_data_l_o all 0
  - mem_sel_o 0
  - pending cleared
- Request latency:
  - Data pulse at edge N: pending set at N+1, mem_req_o at N+2.
  - im_rd_i seen in IDLE at N: mem_req_o at N+1.
- Completion: mem_ack_i sampled at edge M → done/valid pulse and state IDLE at M+1. The next mem_req_o is at M+2 at the earliest, so there is one idle bus cycle between transfers.
- Minimum fetch round trip is 2 cycles with a zero-wait ack.
- A data request pulsed during a FETCH is served immediately after that fetch completes, before the next fetch.
- Reset mid-transfer: IDLE and mem_req_o=0 at the next edge. Pending is dropped, no done pulses are issued, and any late ack is ignored.
- All outputs are registered; there is no combinational path from mem_ack_i to the core.

## Configuration
- RV_ARB_ROUND_ROBIN_EN defined: a last-grant bit is kept, reset to "data". When both a data request and a fetch are pending in IDLE, the requester not granted last wins. Fetch bandwidth is guaranteed at ≥50% under continuous data traffic.
- Undefined: fixed data-over-fetch priority. The last-grant bit is not built.

## Test plan
- Zero-wait fetch: im_rd_i=1, im_addr_i=0x100, ack the cycle after req with mem_data_i=0x00000013 → im_valid_o=1 two edges after request, im_data_o=0x13, mem_sel_o=4'hF, mem_we_o=0.
- Store during fetch: fetch in flight with ack delayed 3 cycles; dm_store_i pulse with addr 0x2000, data 0xDEADBEEF, sel 4'b0011 → dm_ready_o drops next cycle; after the fetch ack, a DSTORE grant with mem_we_o=1 and exact fields; one dm_store_done_o pulse; dm_ready_o returns 1.
- Branch discard: fetch at 0x200, im_addr_i changes to 0x300 before ack → no im_valid_o; next grant fetches 0x300.
- Load back-pressure: ack delayed 5 cycles on a load of 0x40 returning 0x12345678 → dm_load_done_o a single pulse 1 cycle after ack, dm_data_l_o=0x12345678, mem_req_o held constant throughout.
- Contention (both builds): continuous dm_load_i pulses plus im_rd_i=1 → without the macro no fetch is granted while data is pending; with RV_ARB_ROUND_ROBIN_EN grants alternate data/fetch.
- Reset mid-DLOAD: assert rst_i while mem_req_o=1, then ack → all outputs at reset values next edge, no dm_load_done_o.
